// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among N byte producers.
// It issues one frame at a time, tracks the serializer's done level, and has a watchdog on every frame.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1024,
    parameter int IFG     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         req_sent,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 err_timeout
);

    localparam int GW = $clog2(N);
    localparam int WW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = (IFG > 0) ? $clog2(IFG + 1) : 1;
    localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] GAP_LOAD = IW'((IFG > 0) ? IFG - 1 : 0);

    // IDLE arbitrate | START issue byte | ACK await done low | WAIT_DONE await done high | GAP inter-frame idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic [N-1:0]    ready_q, ready_d;
    logic [N-1:0]    sent_q, sent_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [IW-1:0]   gap_q, gap_d;

    logic [GW-1:0]   cand;
    logic [GW-1:0]   pick;
    logic            pick_vld;

    // Scan from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            cand = GW'((int'(last_q) + k) % N);
            if (req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = '0;
        sent_d  = '0;
        start_d = 1'b0;
        err_d   = err_q;
        wd_d    = wd_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d       = pick;
                    data_d        = req_data[{pick, 3'b000} +: 8];
                    ready_d[pick] = 1'b1;
                    state_d       = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                wd_d    = WD_LOAD;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (wd_q == '0) begin
                    err_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WW'(1);
                    if (!tx_done) begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    sent_d[grant_q] = 1'b1;
                    last_d          = grant_q;
                    if (IFG > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= GW'(N - 1);
            grant_q <= '0;
            data_q  <= 8'h00;
            ready_q <= '0;
            sent_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            sent_q  <= sent_d;
            start_q <= start_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
        end
    end

    assign req_ready   = ready_q;
    assign req_sent    = sent_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx done-level model.
// Expected grants and completions are queued at stimulus time and popped as the DUT produces them.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int IFG     = 5;
    localparam int FRAME   = 10;
    // tx_start cycle to req_sent cycle: 1 for the model to sample start, FRAME, 1 for the registered pulse
    localparam int LAT     = FRAME + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_sent;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err_timeout;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .IFG(IFG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_sent(req_sent), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
        .grant_id(grant_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: done level drops m_ack_dly cycles after start is sampled, rises FRAME cycles after.
    logic m_done = 1'b1;
    logic m_done_init = 1'b1;
    logic m_act = 1'b0;
    logic m_stall = 1'b0;
    int   m_t = 0;
    int   m_ack_dly = 0;
    assign tx_done = m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_done <= m_done_init;
            m_act  <= 1'b0;
            m_t    <= 0;
        end else if (tx_start) begin
            m_act <= 1'b1;
            m_t   <= 0;
            if (m_ack_dly == 0) m_done <= 1'b0;
        end else if (m_act && !m_stall) begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_ack_dly) m_done <= 1'b0;
            if (m_t + 1 == FRAME) begin
                m_done <= 1'b1;
                m_act  <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_start_q[$];
    logic [3:0] exp_sent_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_start / req_sent and checks timing relations.
    logic [3:0] prev_ready = '0;
    logic       err_prev = 1'b0;
    logic       inflight = 1'b0;
    logic       have_sent = 1'b0;
    logic       check_ifg = 1'b0;
    logic [7:0] cur_data = '0;
    int         start_cyc = 0;
    int         sent_cyc = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] s;
        if (rst) begin
            inflight  = 1'b0;
            have_sent = 1'b0;
        end else begin
            if (tx_start) begin
                check_eq("start_expected", exp_start_q.size() != 0, 1);
                if (exp_start_q.size() != 0) begin
                    e = exp_start_q.pop_front();
                    check_eq("grant_id", grant_id, e.id);
                    check_eq("tx_data", tx_data, e.data);
                    check_eq("ready_before_start", prev_ready, 32'(1) << e.id);
                    cur_data = e.data;
                end
                check_eq("start_after_prev_sent", inflight, 0);
                if (check_ifg && have_sent) check_eq("ifg_spacing", cyc - sent_cyc, IFG + 2);
                inflight  = 1'b1;
                start_cyc = cyc;
            end
            if (req_sent != '0) begin
                check_eq("sent_expected", exp_sent_q.size() != 0, 1);
                if (exp_sent_q.size() != 0) begin
                    s = exp_sent_q.pop_front();
                    check_eq("req_sent", req_sent, s);
                end
                check_eq("frame_latency", cyc - start_cyc, LAT);
                check_eq("tx_data_stable", tx_data, cur_data);
                inflight  = 1'b0;
                have_sent = 1'b1;
                sent_cyc  = cyc;
            end
            if (err_timeout && !err_prev) begin
                inflight  = 1'b0;
                have_sent = 1'b0;
            end
        end
        prev_ready = req_ready;
        err_prev   = err_timeout;
    end

    function automatic logic probe(input int which);
        case (which)
            0:       return tx_start;
            1:       return |req_sent;
            2:       return |req_ready;
            default: return err_timeout;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(which) && n < budget);
        check_eq(tag, probe(which), 1);
        t = cyc;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic do_sent);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_start_q.push_back(e);
        if (do_sent) exp_sent_q.push_back(4'(1 << id));
    endtask

    int t0, t1;
    logic [7:0] rr_bytes [4];

    initial begin
        rr_bytes[0] = 8'h10; rr_bytes[1] = 8'h11; rr_bytes[2] = 8'h12; rr_bytes[3] = 8'h13;

        // reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_req_sent", req_sent, 0);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_err", err_timeout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single requester, valid dropped after acceptance
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        push(0, 8'hA5, 1'b1);
        t0 = cyc;
        wait_for("wait_ready_single", 2, 5, t1);
        check_eq("ready_latency", t1 - t0, 1);
        check_eq("ready_onehot", req_ready, 4'b0001);
        req_valid = '0;
        wait_for("wait_start_single", 0, 5, t1);
        check_eq("start_latency", t1 - t0, 2);
        wait_for("wait_sent_single", 1, 40, t1);
        repeat (30) @(negedge clk);
        check_eq("single_idle_busy", busy, 0);
        check_eq("grant_hold_idle", grant_id, 0);

        // round robin with all four held valid
        do_reset(2);
        check_ifg = 1'b1;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) push(i % 4, rr_bytes[i % 4], 1'b1);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) wait_for("wait_sent_rr", 1, 60, t1);
        req_valid = '0;
        check_ifg = 1'b0;
        repeat (20) @(negedge clk);

        // stale high done with slow acknowledge
        m_done_init = 1'b1;
        m_ack_dly   = 4;
        do_reset(2);
        repeat (5) @(negedge clk);
        req_data[23:16] = 8'h3C;
        req_valid       = 4'b0100;
        push(2, 8'h3C, 1'b1);
        wait_for("wait_start_stale", 0, 6, t1);
        req_valid = '0;
        wait_for("wait_sent_stale", 1, 40, t1);
        m_ack_dly = 0;
        repeat (10) @(negedge clk);

        // watchdog: requester 0 never completes, requester 1 is served next
        do_reset(2);
        m_stall       = 1'b1;
        req_data[7:0] = 8'h77;
        req_data[15:8] = 8'h88;
        req_valid     = 4'b0011;
        push(0, 8'h77, 1'b0);
        push(1, 8'h88, 1'b1);
        wait_for("wait_start_wd", 0, 6, t0);
        wait_for("wait_err", 3, 40, t1);
        check_eq("wd_latency", t1 - t0, TIMEOUT);
        check_eq("wd_busy_idle", busy, 0);
        m_stall = 1'b0;
        wait_for("wait_start_after_wd", 0, 6, t1);
        wait_for("wait_sent_after_wd", 1, 40, t1);
        req_valid = '0;
        repeat (15) @(negedge clk);
        check_eq("err_sticky", err_timeout, 1);
        check_eq("grant_after_wd", grant_id, 1);
        do_reset(1);
        check_eq("err_cleared", err_timeout, 0);

        // reset during WAIT_DONE
        repeat (2) @(negedge clk);
        req_data[23:16] = 8'h99;
        req_valid       = 4'b0100;
        push(2, 8'h99, 1'b0);
        wait_for("wait_start_mid", 0, 6, t1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_req_ready", req_ready, 0);
        check_eq("mid_req_sent", req_sent, 0);
        check_eq("mid_tx_start", tx_start, 0);
        check_eq("mid_tx_data", tx_data, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_grant_id", grant_id, 0);
        check_eq("mid_err", err_timeout, 0);
        rst = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b1111;
        push(0, 8'hA0, 1'b1);
        wait_for("wait_ready_mid", 2, 5, t1);
        req_valid = '0;
        wait_for("wait_sent_mid", 1, 40, t1);
        repeat (20) @(negedge clk);

        check_eq("leftover_starts", exp_start_q.size(), 0);
        check_eq("leftover_sents", exp_sent_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N byte-producing requesters using round-robin arbitration. The block accepts one byte per grant and drives the serializer's start/data inputs. It then tracks the serializer's done level through the frame and reports per-requester completion. A watchdog flags a serializer that never completes. It sits between the UART client logic (console, status reporter, debug dump) and uart_tx.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 1024, max cycles from tx_start to tx_done rising before abort
IFG, 0, idle cycles inserted after each completed frame before next arbitration

Ports:
clk  input  1  sole clock
rst  input  1  reset; one clock; reset is synchronous and active-high
req_valid  input  N  requester i has a byte pending
req_data  input  8*N  byte of requester i at bits [8*i+7:8*i]
req_ready  output  N  one-hot, 1-cycle pulse: byte of requester i accepted this cycle
req_sent  output  N  one-hot, 1-cycle pulse: frame of requester i completed
tx_start  output  1  1-cycle start pulse to uart_tx
tx_data  output  8  byte to uart_tx, stable from tx_start until frame end
tx_done  input  1  uart_tx done level (high after stop bit, cleared when start accepted)
busy  output  1  high in any state except IDLE
grant_id  output  $clog2(N)  index of current/last granted requester
err_timeout  output  1  sticky watchdog error

Behaviour:
- Reset (rst sampled high at posedge) gives: state=IDLE; req_ready=0, req_sent=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0, err_timeout=0. The RR pointer is set so requester 0 has top priority. rst mid-frame aborts immediately; no req_sent is issued for the in-flight byte.
- States: IDLE, START, ACK, WAIT_DONE, GAP.
- IDLE: if req_valid!=0, select the first set bit searching from (last_grant+1) mod N upward with wrap. On that same edge:
  - register grant_id and tx_data=req_data[grant];
  - pulse req_ready[grant] for exactly one cycle;
  - go to START.
  - If req_valid==0, stay in IDLE.
- START: tx_start=1 for exactly this one cycle. Clear the watchdog counter. Go to ACK.
- ACK: wait for tx_done==0, which confirms the serializer accepted start. Then go to WAIT_DONE. The watchdog counts in this state.
- WAIT_DONE: on tx_done==1:
  - pulse req_sent[grant_id] for one cycle;
  - set last_grant=grant_id;
  - go to GAP if IFG>0, else IDLE.
- GAP: count IFG cycles, then go to IDLE.
- The watchdog counts each cycle in ACK and WAIT_DONE. If it reaches TIMEOUT:
  - set err_timeout=1 (sticky until rst);
  - set last_grant=grant_id so the failing requester loses priority;
  - issue no req_sent;
  - go to IDLE.
- tx_done level at the start of a frame is ignored. The block never treats the stale high done from the previous frame as completion; the ACK state exists for this reason.
- req_valid deasserting after req_ready has no effect on the in-flight frame. req_valid of the granted requester is not sampled again until the next IDLE.
- Arbitration latency: req_valid high in IDLE gives req_ready on the next edge and tx_start one cycle later.
- Back-to-back throughput: a requester whose valid stays high is re-granted only after all other active requesters have been served.
- grant_id holds its value while in IDLE.
- Counter widths are $clog2(TIMEOUT+1) and $clog2(IFG+1), minimum 1. There is no wrap; the counters saturate at the terminal value.

Test Plan:
- Single requester: rst 2 cycles, then req_valid=4'b0001 with data 8'hA5. Required: req_ready[0] pulse, then tx_start pulse one cycle later with tx_data=A5. With a uart_tx model attached, exactly one req_sent[0] after done rises (~310 cycles); no second frame once valid drops.
- Round-robin: all four valid with data 8'h10/11/12/13 held high. Required: grant order 0,1,2,3,0. Each tx_start only after the previous req_sent. tx_data matches the granted byte.
- Stale done: tx_done model held high before the first frame. Required: no req_sent until done goes low and then high again.
- Watchdog: tx_done stuck low after start, TIMEOUT=16. Required: err_timeout=1 exactly 16 cycles after entering ACK/WAIT_DONE, no req_sent, return to IDLE, next grant goes to the next requester. err_timeout stays 1 until rst.
- IFG=5, two requesters valid. Required: tx_start for the second frame exactly 5+2 cycles after the first req_sent pulse.
- Reset mid-frame: assert rst during WAIT_DONE. Required: all outputs at reset values the next cycle, no req_sent, and the following grant goes to requester 0.
